// File: rtl/parity_scan_unit.sv
// Serial parity scanner: walks a DATA_WIDTH-bit word STEP bits per cycle,
// accumulating the ones count, then reports parity flags and a generated parity bit.
module parity_scan_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int STEP       = 1
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              start,
    input  logic                              abort,
    input  logic                              odd_mode,
    input  logic [DATA_WIDTH-1:0]             data_in,
    output logic                              busy,
    output logic                              done,
    output logic                              even_parity,
    output logic                              odd_parity,
    output logic                              parity_bit,
    output logic [$clog2(DATA_WIDTH+1)-1:0]   ones_count
);

    localparam int N  = DATA_WIDTH / STEP;
    localparam int CW = $clog2(DATA_WIDTH + 1);
    localparam int SW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        RESULT = 2'd2
    } state_t;

    function automatic logic [CW-1:0] chunk_ones(input logic [STEP-1:0] chunk);
        logic [CW-1:0] n;
        n = {CW{1'b0}};
        for (int i = 0; i < STEP; i++) begin
            n = n + {{(CW-1){1'b0}}, chunk[i]};
        end
        return n;
    endfunction

    state_t                state_q, state_d;
    logic [DATA_WIDTH-1:0] shift_q, shift_d;
    logic [CW-1:0]         acc_q, acc_d;
    logic [SW-1:0]         step_q, step_d;
    logic                  mode_q, mode_d;
    logic                  busy_q, busy_d;
    logic                  done_q, done_d;
    logic                  even_q, even_d;
    logic                  odd_q, odd_d;
    logic                  pbit_q, pbit_d;
    logic [CW-1:0]         ones_q, ones_d;
    logic [CW-1:0]         sum_s;
    logic                  launch_s;

    // Next-state and next-output logic for the scan sequencer
    always_comb begin
        state_d  = state_q;
        shift_d  = shift_q;
        acc_d    = acc_q;
        step_d   = step_q;
        mode_d   = mode_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        even_d   = even_q;
        odd_d    = odd_q;
        pbit_d   = pbit_q;
        ones_d   = ones_q;
        sum_s    = acc_q + chunk_ones(shift_q[STEP-1:0]);
        launch_s = start & ~abort;

        case (state_q)
            IDLE, RESULT: begin
                // The edge leaving RESULT also samples start, so words can run every N+1 cycles
                if (launch_s) begin
                    state_d = SCAN;
                    shift_d = data_in;
                    mode_d  = odd_mode;
                    acc_d   = {CW{1'b0}};
                    step_d  = {SW{1'b0}};
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            SCAN: begin
                if (abort) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end else begin
                    acc_d   = sum_s;
                    shift_d = shift_q >> STEP;
                    step_d  = step_q + SW'(1);
                    busy_d  = 1'b1;
                    if (step_q == SW'(N - 1)) begin
                        state_d = RESULT;
                        done_d  = 1'b1;
                        ones_d  = sum_s;
                        even_d  = ~sum_s[0];
                        odd_d   = sum_s[0];
                        pbit_d  = sum_s[0] ^ mode_q;
                    end else begin
                        state_d = SCAN;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            shift_q <= {DATA_WIDTH{1'b0}};
            acc_q   <= {CW{1'b0}};
            step_q  <= {SW{1'b0}};
            mode_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            even_q  <= 1'b0;
            odd_q   <= 1'b0;
            pbit_q  <= 1'b0;
            ones_q  <= {CW{1'b0}};
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            acc_q   <= acc_d;
            step_q  <= step_d;
            mode_q  <= mode_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            even_q  <= even_d;
            odd_q   <= odd_d;
            pbit_q  <= pbit_d;
            ones_q  <= ones_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign even_parity = even_q;
    assign odd_parity  = odd_q;
    assign parity_bit  = pbit_q;
    assign ones_count  = ones_q;

endmodule

// File: tb/tb_parity_scan_unit.sv
// Randomised self-checking bench for parity_scan_unit in three shapes:
// 8-bit/STEP 1, 16-bit/STEP 4 and 8-bit/STEP 8.
module tb_parity_scan_unit;

    logic        clk;
    logic        rst;
    logic [2:0]  start_v, abort_v, mode_v;
    logic [2:0]  busy_v, done_v, even_v, odd_v, pb_v;
    logic [7:0]  d0, d2;
    logic [15:0] d1;
    logic [3:0]  cnt0, cnt2;
    logic [4:0]  cnt1;

    int   n_cmp = 0;
    int   n_err = 0;
    int   n_of[3] = '{8, 4, 1};
    int   exp_cnt[3];
    logic exp_even[3], exp_odd[3], exp_pb[3];

    parity_scan_unit #(.DATA_WIDTH(8), .STEP(1)) u0 (
        .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]), .odd_mode(mode_v[0]),
        .data_in(d0), .busy(busy_v[0]), .done(done_v[0]), .even_parity(even_v[0]),
        .odd_parity(odd_v[0]), .parity_bit(pb_v[0]), .ones_count(cnt0));

    parity_scan_unit #(.DATA_WIDTH(16), .STEP(4)) u1 (
        .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]), .odd_mode(mode_v[1]),
        .data_in(d1), .busy(busy_v[1]), .done(done_v[1]), .even_parity(even_v[1]),
        .odd_parity(odd_v[1]), .parity_bit(pb_v[1]), .ones_count(cnt1));

    parity_scan_unit #(.DATA_WIDTH(8), .STEP(8)) u2 (
        .clk(clk), .rst(rst), .start(start_v[2]), .abort(abort_v[2]), .odd_mode(mode_v[2]),
        .data_in(d2), .busy(busy_v[2]), .done(done_v[2]), .even_parity(even_v[2]),
        .odd_parity(odd_v[2]), .parity_bit(pb_v[2]), .ones_count(cnt2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] cnt_of(input int w);
        case (w)
            0:       return {28'd0, cnt0};
            1:       return {27'd0, cnt1};
            default: return {28'd0, cnt2};
        endcase
    endfunction

    task automatic set_data(input int w, input logic [15:0] v);
        case (w)
            0:       d0 = v[7:0];
            1:       d1 = v;
            default: d2 = v[7:0];
        endcase
    endtask

    task automatic chk_results(input int w, input string tag);
        chk({tag, ".cnt"},  cnt_of(w),          exp_cnt[w]);
        chk({tag, ".even"}, {31'd0, even_v[w]}, {31'd0, exp_even[w]});
        chk({tag, ".odd"},  {31'd0, odd_v[w]},  {31'd0, exp_odd[w]});
        chk({tag, ".pbit"}, {31'd0, pb_v[w]},   {31'd0, exp_pb[w]});
    endtask

    task automatic chk_hs(input int w, input string tag, input logic eb, input logic ed);
        chk({tag, ".busy"}, {31'd0, busy_v[w]}, {31'd0, eb});
        chk({tag, ".done"}, {31'd0, done_v[w]}, {31'd0, ed});
    endtask

    // Full operation; returns right after the done edge with start low
    task automatic run(input int w, input logic [15:0] data, input logic md, input string tag);
        int ones;
        ones = (w == 1) ? $countones(data) : $countones(data[7:0]);
        start_v[w] = 1'b1; mode_v[w] = md; set_data(w, data);
        tick();
        chk_hs(w, {tag, ".launch"}, 1'b1, 1'b0);
        for (int c = 1; c <= n_of[w]; c++) begin
            start_v[w] = 1'($urandom_range(0, 1));
            mode_v[w]  = 1'($urandom_range(0, 1));
            set_data(w, 16'($urandom));
            tick();
            if (c < n_of[w]) chk_hs(w, {tag, ".scan"}, 1'b1, 1'b0);
        end
        start_v[w] = 1'b0;
        exp_cnt[w]  = ones;
        exp_odd[w]  = (ones % 2) == 1;
        exp_even[w] = (ones % 2) == 0;
        exp_pb[w]   = ((ones % 2) == 1) ^ md;
        chk_hs(w, {tag, ".result"}, 1'b1, 1'b1);
        chk_results(w, tag);
    endtask

    task automatic idle_tick(input int w, input string tag);
        start_v[w] = 1'b0;
        tick();
        chk_hs(w, tag, 1'b0, 1'b0);
    endtask

    // Start then abort at edge k+ab (1 <= ab <= N): no done, results unchanged
    task automatic run_abort(input int w, input logic [15:0] data, input logic md, input int ab, input string tag);
        start_v[w] = 1'b1; mode_v[w] = md; set_data(w, data);
        tick();
        for (int c = 1; c <= ab; c++) begin
            start_v[w] = 1'($urandom_range(0, 1));
            set_data(w, 16'($urandom));
            if (c == ab) abort_v[w] = 1'b1;
            tick();
            if (c < ab) chk_hs(w, {tag, ".scan"}, 1'b1, 1'b0);
        end
        abort_v[w] = 1'b0; start_v[w] = 1'b0;
        chk_hs(w, {tag, ".abort"}, 1'b0, 1'b0);
        chk_results(w, {tag, ".hold"});
        idle_tick(w, {tag, ".after"});
    endtask

    initial begin
        rst = 1'b1; start_v = 3'b000; abort_v = 3'b000; mode_v = 3'b000;
        d0 = 8'h00; d1 = 16'h0000; d2 = 8'h00;
        for (int w = 0; w < 3; w++) begin
            exp_cnt[w] = 0; exp_even[w] = 1'b0; exp_odd[w] = 1'b0; exp_pb[w] = 1'b0;
        end
        tick(); tick();
        rst = 1'b0;
        for (int w = 0; w < 3; w++) begin
            chk_hs(w, "reset", 1'b0, 1'b0);
            chk_results(w, "reset");
        end

        run(0, 16'h0091, 1'b0, "b10010001");
        idle_tick(0, "b10010001.idle");
        run(0, 16'h00FF, 1'b1, "ff_odd");
        run(0, 16'h0000, 1'b0, "b2b_00");
        idle_tick(0, "b2b.idle");
        run(1, 16'hF0F1, 1'b0, "w16_f0f1");
        idle_tick(1, "w16.idle");
        run(2, 16'h00A7, 1'b1, "n1_a7");
        idle_tick(2, "n1.idle");

        run(0, 16'h0055, 1'b1, "pre_abort");
        idle_tick(0, "pre_abort.idle");
        run_abort(0, 16'h000F, 1'b0, 3, "abort3");
        run(0, 16'h0001, 1'b0, "post_abort");
        idle_tick(0, "post_abort.idle");

        // Reset in the middle of a scan clears everything
        start_v[0] = 1'b1; d0 = 8'h5A;
        tick();
        start_v[0] = 1'b0;
        tick(); tick(); tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int w = 0; w < 3; w++) begin
            exp_cnt[w] = 0; exp_even[w] = 1'b0; exp_odd[w] = 1'b0; exp_pb[w] = 1'b0;
            chk_hs(w, "midrst", 1'b0, 1'b0);
            chk_results(w, "midrst");
        end
        idle_tick(0, "midrst.idle");

        start_v[0] = 1'b1; abort_v[0] = 1'b1;
        tick();
        start_v[0] = 1'b0; abort_v[0] = 1'b0;
        chk_hs(w_zero(), "start_abort", 1'b0, 1'b0);
        idle_tick(0, "start_abort.idle");

        for (int w = 0; w < 3; w++) begin
            for (int i = 0; i < 20; i++) begin
                int sel;
                sel = $urandom_range(0, 3);
                if (sel == 0) begin
                    run_abort(w, 16'($urandom), 1'($urandom_range(0, 1)),
                              $urandom_range(1, n_of[w]), "rnd_abort");
                end else begin
                    run(w, 16'($urandom), 1'($urandom_range(0, 1)), "rnd");
                    if (sel == 1) idle_tick(w, "rnd.idle");
                end
            end
            idle_tick(w, "rnd.end");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    function automatic int w_zero();
        return 0;
    endfunction

endmodule
